cdc_host_bridge: RTL and testbench

- Upstream neighbour of the address decoder. Receives host register/coefficient-RAM accesses from an asynchronous host domain over a 4-phase req/ack handshake.
- Synchronises the handshake into the FIR clock and issues exactly one single-cycle access on CDC_A/CDC_D/CDC_wr per host transaction.
- For reads, captures the readback word and returns it on host_Q before acknowledging.
- The decoder consumes CDC_A/CDC_wr; the readback mux downstream of the decoder drives CDC_Q.

---
 rtl/fir_pkg.sv | 16 +
 rtl/sync_ff.sv | 25 ++
 rtl/cdc_host_bridge.sv | 123 ++++++++++++
 tb/tb_cdc_host_bridge.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR host-access path: default bus widths and
// the state encoding of the host CDC bridge.
package fir_pkg;

    localparam int FIR_ADDR_W = 6;
    localparam int FIR_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        RD_WAIT,
        ACK,
        DONE
    } bridge_state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop level synchroniser for a single asynchronous input bit.
// Cleared by the asynchronous active-low reset; usable for any async level.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic [STAGES-1:0] r_chain;

    // Shift the raw input through the flop chain; the last stage is the safe copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/cdc_host_bridge.sv
// Host-to-FIR clock-domain bridge. Turns one 4-phase host req/ack handshake
// into exactly one single-cycle access on the CDC bus, and for reads
// returns the readback word on host_Q before acknowledging.
module cdc_host_bridge
    import fir_pkg::*;
#(
    parameter int ADDR_W      = FIR_ADDR_W,
    parameter int DATA_W      = FIR_DATA_W,
    parameter int SYNC_STAGES = 2,
    parameter int RD_LAT      = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_A,
    input  logic [DATA_W-1:0] host_D,
    input  logic              host_wr,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_Q,
    output logic [ADDR_W-1:0] CDC_A,
    output logic [DATA_W-1:0] CDC_D,
    output logic              CDC_wr,
    output logic              CDC_valid,
    input  logic [DATA_W-1:0] CDC_Q
);

    // The counter holds the number of RD_WAIT cycles still to go before the
    // readback word is valid; the ISSUE cycle itself already counts as one.
    localparam int CNT_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'((RD_LAT > 0) ? RD_LAT - 1 : 0);

    bridge_state_t     r_state;
    logic              r_wrQ;
    logic [CNT_W-1:0]  r_latCnt;
    logic              r_hostAck;
    logic [DATA_W-1:0] r_hostQ;
    logic [ADDR_W-1:0] r_cdcA;
    logic [DATA_W-1:0] r_cdcD;
    logic              r_cdcWr;
    logic              r_cdcValid;
    logic              w_reqS;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_reqSync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (host_req),
        .o_sync  (w_reqS)
    );

    // Handshake FSM: all outputs are direct flops so nothing glitches across the boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_wrQ      <= 1'b0;
            r_latCnt   <= '0;
            r_hostAck  <= 1'b0;
            r_hostQ    <= '0;
            r_cdcA     <= '0;
            r_cdcD     <= '0;
            r_cdcWr    <= 1'b0;
            r_cdcValid <= 1'b0;
        end else begin
            r_cdcValid <= 1'b0;
            r_cdcWr    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_reqS) begin
                        r_cdcA     <= host_A;
                        r_cdcD     <= host_D;
                        r_wrQ      <= host_wr;
                        r_cdcValid <= 1'b1;
                        r_cdcWr    <= host_wr;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (r_wrQ) begin
                        r_hostAck <= 1'b1;
                        r_state   <= ACK;
                    end else if (RD_LAT == 0) begin
                        r_hostQ   <= CDC_Q;
                        r_hostAck <= 1'b1;
                        r_state   <= ACK;
                    end else begin
                        r_latCnt <= LAT_LOAD;
                        r_state  <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (r_latCnt == '0) begin
                        r_hostQ   <= CDC_Q;
                        r_hostAck <= 1'b1;
                        r_state   <= ACK;
                    end else begin
                        r_latCnt <= r_latCnt - 1'b1;
                    end
                end
                ACK: begin
                    if (!w_reqS) begin
                        r_hostAck <= 1'b0;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign host_ack  = r_hostAck;
    assign host_Q    = r_hostQ;
    assign CDC_A     = r_cdcA;
    assign CDC_D     = r_cdcD;
    assign CDC_wr    = r_cdcWr;
    assign CDC_valid = r_cdcValid;

endmodule

// File: tb/tb_cdc_host_bridge.sv
// Bench for cdc_host_bridge: three builds (RD_LAT = 1, 0, 3) share one host
// interface. Each has a readback model that presents the read word only in
// the cycle RD_LAT after its strobe, and a junk value otherwise.
module tb_cdc_host_bridge;

    localparam logic [15:0] JUNK = 16'hDEAD;
    localparam int NDUT = 3;

    typedef struct {
        logic        wr;
        logic [5:0]  addr;
        logic [15:0] data;
        logic [15:0] rdWord;
        logic [15:0] expQ;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        host_req;
    logic [5:0]  host_A;
    logic [15:0] host_D;
    logic        host_wr;
    logic [15:0] rdWord;

    logic        ack      [NDUT];
    logic [15:0] hostQ    [NDUT];
    logic [5:0]  cdcA     [NDUT];
    logic [15:0] cdcD     [NDUT];
    logic        cdcWr    [NDUT];
    logic        cdcValid [NDUT];
    logic [15:0] cdcQ     [NDUT];

    int   cyc = 0;
    int   nCompared = 0;
    int   nMismatched = 0;
    vec_t sbQ [NDUT][$];
    vec_t monE;
    vec_t vecs [6];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int latOf(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : gDut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);

        cdc_host_bridge #(
            .ADDR_W      (6),
            .DATA_W      (16),
            .SYNC_STAGES (2),
            .RD_LAT      (LAT)
        ) uDut (
            .clk       (clk),
            .rst_n     (rst_n),
            .host_req  (host_req),
            .host_A    (host_A),
            .host_D    (host_D),
            .host_wr   (host_wr),
            .host_ack  (ack[g]),
            .host_Q    (hostQ[g]),
            .CDC_A     (cdcA[g]),
            .CDC_D     (cdcD[g]),
            .CDC_wr    (cdcWr[g]),
            .CDC_valid (cdcValid[g]),
            .CDC_Q     (cdcQ[g])
        );

        if (LAT == 0) begin : gComb
            assign cdcQ[g] = cdcValid[g] ? rdWord : JUNK;
        end else begin : gPipe
            logic [3:0]       vPipe = '0;
            logic [3:0][15:0] dPipe = '0;
            always @(posedge clk) begin
                vPipe <= {vPipe[2:0], cdcValid[g]};
                dPipe <= {dPipe[2:0], rdWord};
            end
            assign cdcQ[g] = vPipe[LAT-1] ? dPipe[LAT-1] : JUNK;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every strobe must match the oldest expected access
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int k = 0; k < NDUT; k++) begin
                if (cdcValid[k]) begin
                    if (sbQ[k].size() == 0) begin
                        checkOutput($sformatf("unexpected_strobe[%0d]", k), 32'(cdcA[k]), 32'hFFFF_FFFF);
                    end else begin
                        monE = sbQ[k].pop_front();
                        checkOutput($sformatf("CDC_A[%0d]", k), 32'(cdcA[k]), 32'(monE.addr));
                        checkOutput($sformatf("CDC_D[%0d]", k), 32'(cdcD[k]), 32'(monE.data));
                        checkOutput($sformatf("CDC_wr[%0d]", k), 32'(cdcWr[k]), 32'(monE.wr));
                    end
                end else if (cdcWr[k]) begin
                    checkOutput($sformatf("wr_without_valid[%0d]", k), 32'(cdcWr[k]), 32'd0);
                end
            end
        end
    end

    task automatic checkIdleOutputs(input string tag);
        for (int k = 0; k < NDUT; k++) begin
            checkOutput($sformatf("%s_ack[%0d]", tag, k), 32'(ack[k]), 32'd0);
            checkOutput($sformatf("%s_hostQ[%0d]", tag, k), 32'(hostQ[k]), 32'd0);
            checkOutput($sformatf("%s_cdcA[%0d]", tag, k), 32'(cdcA[k]), 32'd0);
            checkOutput($sformatf("%s_cdcD[%0d]", tag, k), 32'(cdcD[k]), 32'd0);
            checkOutput($sformatf("%s_cdcWr[%0d]", tag, k), 32'(cdcWr[k]), 32'd0);
            checkOutput($sformatf("%s_cdcValid[%0d]", tag, k), 32'(cdcValid[k]), 32'd0);
        end
    endtask

    // Drive a request at a falling edge and queue the expected access for each build
    task automatic applyStimulus(input vec_t v, output int n0);
        @(negedge clk);
        host_A   = v.addr;
        host_D   = v.data;
        host_wr  = v.wr;
        rdWord   = v.rdWord;
        for (int k = 0; k < NDUT; k++) sbQ[k].push_back(v);
        host_req = 1'b1;
        n0       = cyc;
    endtask

    // Follow one full handshake; n0 is the cycle count at the falling edge
    // before the first rising edge that samples host_req high
    task automatic completeTxn(input vec_t v, input int n0);
        int validAt [NDUT];
        int ackAt   [NDUT];
        int fallAt  [NDUT];
        int dropCyc;
        bit allDone;
        for (int k = 0; k < NDUT; k++) begin
            validAt[k] = -1;
            ackAt[k]   = -1;
            fallAt[k]  = -1;
        end
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            allDone = 1'b1;
            for (int k = 0; k < NDUT; k++) begin
                if (cdcValid[k] && validAt[k] < 0) validAt[k] = cyc;
                if (ack[k] && ackAt[k] < 0) begin
                    ackAt[k] = cyc;
                    checkOutput($sformatf("hostQ_at_ack[%0d]", k), 32'(hostQ[k]), 32'(v.expQ));
                end
                if (ackAt[k] < 0) allDone = 1'b0;
            end
            if (allDone) break;
        end
        for (int k = 0; k < NDUT; k++) begin
            checkOutput($sformatf("req_to_strobe[%0d]", k), 32'(validAt[k] - n0), 32'd3);
            checkOutput($sformatf("strobe_to_ack[%0d]", k), 32'(ackAt[k] - validAt[k]),
                        32'(v.wr ? 1 : latOf(k) + 1));
        end
        host_req = 1'b0;
        dropCyc  = cyc;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            allDone = 1'b1;
            for (int k = 0; k < NDUT; k++) begin
                if (!ack[k] && fallAt[k] < 0) fallAt[k] = cyc;
                if (fallAt[k] < 0) allDone = 1'b0;
            end
            if (allDone) break;
        end
        for (int k = 0; k < NDUT; k++) begin
            checkOutput($sformatf("drop_to_ack_fall[%0d]", k), 32'(fallAt[k] - dropCyc), 32'd3);
            checkOutput($sformatf("sb_drained[%0d]", k), 32'(sbQ[k].size()), 32'd0);
        end
    endtask

    initial begin
        int   n0;
        int   validCnt [NDUT];
        int   ackCnt   [NDUT];
        logic [15:0] qAtAck [NDUT];
        vec_t v;

        vecs[0] = '{wr: 1'b1, addr: 6'b000101, data: 16'hA5C3, rdWord: 16'h0000, expQ: 16'h0000};
        vecs[1] = '{wr: 1'b0, addr: 6'b100011, data: 16'h0000, rdWord: 16'h1234, expQ: 16'h1234};
        vecs[2] = '{wr: 1'b1, addr: 6'h1F,     data: 16'hBEEF, rdWord: 16'h0000, expQ: 16'h1234};
        vecs[3] = '{wr: 1'b0, addr: 6'h21,     data: 16'h1111, rdWord: 16'h5A5A, expQ: 16'h5A5A};
        vecs[4] = '{wr: 1'b1, addr: 6'h3F,     data: 16'h0001, rdWord: 16'h0000, expQ: 16'h5A5A};
        vecs[5] = '{wr: 1'b0, addr: 6'h00,     data: 16'hFFFF, rdWord: 16'hFFFF, expQ: 16'hFFFF};

        rst_n    = 1'b0;
        host_req = 1'b0;
        host_A   = '0;
        host_D   = '0;
        host_wr  = 1'b0;
        rdWord   = '0;
        repeat (3) @(negedge clk);
        checkIdleOutputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] table-driven transactions");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], n0);
            completeTxn(vecs[i], n0);
        end

        $display("[TB] sub-cycle glitch on host_req");
        for (int k = 0; k < NDUT; k++) begin
            validCnt[k] = 0;
            ackCnt[k]   = 0;
        end
        @(posedge clk);
        #2 host_req = 1'b1;
        #4 host_req = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            for (int k = 0; k < NDUT; k++) begin
                if (cdcValid[k]) validCnt[k]++;
                if (ack[k]) ackCnt[k]++;
            end
        end
        for (int k = 0; k < NDUT; k++) begin
            checkOutput($sformatf("glitch_strobes[%0d]", k), 32'(validCnt[k]), 32'd0);
            checkOutput($sformatf("glitch_acks[%0d]", k), 32'(ackCnt[k]), 32'd0);
        end

        $display("[TB] request dropped before acknowledge");
        v = '{wr: 1'b0, addr: 6'h2A, data: 16'h0000, rdWord: 16'h0F0F, expQ: 16'h0F0F};
        for (int k = 0; k < NDUT; k++) begin
            validCnt[k] = 0;
            ackCnt[k]   = 0;
            qAtAck[k]   = 16'h0000;
        end
        applyStimulus(v, n0);
        repeat (2) @(negedge clk);
        host_req = 1'b0;
        for (int t = 0; t < 15; t++) begin
            @(negedge clk);
            for (int k = 0; k < NDUT; k++) begin
                if (cdcValid[k]) validCnt[k]++;
                if (ack[k]) begin
                    ackCnt[k]++;
                    qAtAck[k] = hostQ[k];
                end
            end
        end
        for (int k = 0; k < NDUT; k++) begin
            checkOutput($sformatf("early_strobes[%0d]", k), 32'(validCnt[k]), 32'd1);
            checkOutput($sformatf("early_ack_width[%0d]", k), 32'(ackCnt[k]), 32'd1);
            checkOutput($sformatf("early_hostQ[%0d]", k), 32'(qAtAck[k]), 32'h0F0F);
            checkOutput($sformatf("early_sb_drained[%0d]", k), 32'(sbQ[k].size()), 32'd0);
        end

        $display("[TB] reset during read wait");
        v = '{wr: 1'b0, addr: 6'h33, data: 16'h4242, rdWord: 16'h7777, expQ: 16'h7777};
        applyStimulus(v, n0);
        begin
            bit seen = 1'b0;
            for (int t = 0; t < 20 && !seen; t++) begin
                @(negedge clk);
                seen = cdcValid[0];
            end
            checkOutput("reset_test_strobe_seen", 32'(seen), 32'd1);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkIdleOutputs("midreset");
        repeat (2) @(negedge clk);
        for (int k = 0; k < NDUT; k++) sbQ[k].push_back(v);
        rst_n = 1'b1;
        n0    = cyc;
        completeTxn(v, n0);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
